// File: rtl/matmul_sequencer.sv
// Sequences a 2x2 8-bit matrix multiply C = A x B and writes C back into regs 0..3.
// While busy, the register-file write port is owned by the sequencer and pipeline writes are dropped.
module matmul_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] a0_i,
  input  logic [7:0] a1_i,
  input  logic [7:0] a2_i,
  input  logic [7:0] a3_i,
  input  logic [7:0] b0_i,
  input  logic [7:0] b1_i,
  input  logic [7:0] b2_i,
  input  logic [7:0] b3_i,
  input  logic       pipe_write_i,
  input  logic [2:0] pipe_destreg_i,
  input  logic [7:0] pipe_wrt_data_i,
  output logic       rf_write_o,
  output logic [2:0] rf_destreg_o,
  output logic [7:0] rf_wrt_data_o,
  output logic       busy_o,
  output logic       stall_o,
  output logic       done_o,
  output logic       conflict_o
);

  typedef enum logic [2:0] {StIdle, StCapture, StMac, StWrite, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] a_q [4];
  logic [7:0] b_q [4];
  logic [7:0] res_q [4];
  logic [7:0] acc_q;
  logic       conflict_q;

  // MAC step cnt = {e, k}: element e = {i, j}, partial product a[i][k] * b[k][j]
  logic [1:0] e_idx;
  logic       k_idx;
  logic [7:0] a_op, b_op, prod, mac_sum;

  assign e_idx   = cnt_q[2:1];
  assign k_idx   = cnt_q[0];
  assign a_op    = a_q[{e_idx[1], k_idx}];
  assign b_op    = b_q[{k_idx, e_idx[0]}];
  assign prod    = a_op * b_op;
  assign mac_sum = acc_q + prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (start_i) state_d = StCapture;
      end
      StCapture: begin
        cnt_d   = 3'd0;
        state_d = StMac;
      end
      StMac: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          cnt_d   = 3'd0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          cnt_d   = 3'd0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        a_q[i]   <= 8'd0;
        b_q[i]   <= 8'd0;
        res_q[i] <= 8'd0;
      end
      acc_q      <= 8'd0;
      conflict_q <= 1'b0;
    end else begin
      if (state_q == StCapture) begin
        a_q[0] <= a0_i;
        a_q[1] <= a1_i;
        a_q[2] <= a2_i;
        a_q[3] <= a3_i;
        b_q[0] <= b0_i;
        b_q[1] <= b1_i;
        b_q[2] <= b2_i;
        b_q[3] <= b3_i;
      end
      if (state_q == StMac) begin
        if (!k_idx) begin
          acc_q <= prod;
        end else begin
          acc_q        <= mac_sum;
          res_q[e_idx] <= mac_sum;
        end
      end
      if (pipe_write_i && (state_q != StIdle)) conflict_q <= 1'b1;
    end
  end

  always_comb begin
    rf_write_o    = 1'b0;
    rf_destreg_o  = 3'd0;
    rf_wrt_data_o = 8'd0;
    if (state_q == StIdle) begin
      rf_write_o    = pipe_write_i;
      rf_destreg_o  = pipe_destreg_i;
      rf_wrt_data_o = pipe_wrt_data_i;
    end else if (state_q == StWrite) begin
      rf_write_o    = 1'b1;
      rf_destreg_o  = {1'b0, cnt_q[1:0]};
      rf_wrt_data_o = res_q[cnt_q[1:0]];
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign stall_o    = busy_o;
  assign done_o     = (state_q == StDone);
  assign conflict_o = conflict_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a register-file model fed by the DUT write port, checked cycle by
// cycle against an operation timeline and a plain-arithmetic matrix product.
module tb_matmul_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pipe_write = 1'b0;
  logic [2:0] pipe_destreg = 3'd0;
  logic [7:0] pipe_wrt_data = 8'd0;
  logic       rf_write;
  logic [2:0] rf_destreg;
  logic [7:0] rf_wrt_data;
  logic       busy, stall, done, conflict;

  logic [7:0] rf [8];
  logic [7:0] exp_rf [8];
  bit         conf_exp;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  matmul_sequencer u_dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start),
    .a0_i           (rf[0]),
    .a1_i           (rf[1]),
    .a2_i           (rf[2]),
    .a3_i           (rf[3]),
    .b0_i           (rf[4]),
    .b1_i           (rf[5]),
    .b2_i           (rf[6]),
    .b3_i           (rf[7]),
    .pipe_write_i   (pipe_write),
    .pipe_destreg_i (pipe_destreg),
    .pipe_wrt_data_i(pipe_wrt_data),
    .rf_write_o     (rf_write),
    .rf_destreg_o   (rf_destreg),
    .rf_wrt_data_o  (rf_wrt_data),
    .busy_o         (busy),
    .stall_o        (stall),
    .done_o         (done),
    .conflict_o     (conflict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // C[i][j] mod 256, with A = regs 0..3 and B = regs 4..7, both row-major
  function automatic logic [7:0] mat_elem(input logic [7:0] r [8], input int i, input int j);
    int s;
    s = int'(r[2*i]) * int'(r[4+j]) + int'(r[2*i+1]) * int'(r[6+j]);
    return 8'(s % 256);
  endfunction

  task automatic set_reg(input int idx, input logic [7:0] v);
    rf[idx]     = v;
    exp_rf[idx] = v;
  endtask

  task automatic load_default();
    for (int i = 0; i < 8; i++) set_reg(i, 8'(i));
  endtask

  task automatic load_fill(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < 4; i++) set_reg(i, av);
    for (int i = 4; i < 8; i++) set_reg(i, bv);
  endtask

  task automatic cmp_rf();
    for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), rf[i], exp_rf[i]);
  endtask

  // Register file: latch the write port just before the edge, apply it just after
  task automatic commit_rf();
    bit         wv;
    logic [2:0] wd;
    logic [7:0] wx;
    wv = rf_write;
    wd = rf_destreg;
    wx = rf_wrt_data;
    @(posedge clk);
    #1;
    if (wv) rf[wd] = wx;
  endtask

  // Cycle 0 is the IDLE cycle whose closing edge samples start; cycle 14 is DONE.
  task automatic do_op(input bit pw0, input logic [2:0] pw0_dest, input logic [7:0] pw0_data,
                       input int conf_c, input int restart_c, input int rst_c,
                       input bit hold, input bit scramble);
    logic [7:0] c_exp [4];
    bit         wr_e;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      start         = hold || (c == 0) || (c == restart_c);
      pipe_write    = (c == 0) ? pw0 : (c == conf_c);
      pipe_destreg  = (c == 0) ? pw0_dest : 3'($urandom);
      pipe_wrt_data = (c == 0) ? pw0_data : 8'($urandom);
      if (c == rst_c) begin
        reset        = 1'b1;
        start        = 1'b0;
        pipe_write   = 1'b1;
        pipe_destreg = 3'd7;
        #1;
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_conflict", conflict, 0);
        check("rst_rf_write", rf_write, 1);
        check("rst_rf_dest", rf_destreg, pipe_destreg);
        check("rst_rf_data", rf_wrt_data, pipe_wrt_data);
        exp_rf[pipe_destreg] = pipe_wrt_data;
        conf_exp = 1'b0;
        commit_rf();
        reset      = 1'b0;
        pipe_write = 1'b0;
        return;
      end
      #1;
      check($sformatf("busy c%0d", c), busy, c != 0);
      check($sformatf("stall c%0d", c), stall, c != 0);
      check($sformatf("done c%0d", c), done, c == 14);
      check($sformatf("conflict c%0d", c), conflict, conf_exp);
      wr_e = (c == 0) ? pipe_write : (c >= 10 && c <= 13);
      check($sformatf("rf_write c%0d", c), rf_write, wr_e);
      if (c == 0) begin
        check("rf_dest c0", rf_destreg, pipe_destreg);
        check("rf_data c0", rf_wrt_data, pipe_wrt_data);
        if (pipe_write) exp_rf[pipe_destreg] = pipe_wrt_data;
        for (int e = 0; e < 4; e++) c_exp[e] = mat_elem(exp_rf, e / 2, e % 2);
      end else if (wr_e) begin
        check($sformatf("rf_dest c%0d", c), rf_destreg, c - 10);
        check($sformatf("rf_data c%0d", c), rf_wrt_data, c_exp[c-10]);
        exp_rf[c-10] = c_exp[c-10];
      end
      if (c != 0 && pipe_write) conf_exp = 1'b1;
      commit_rf();
      // Disturb the register file mid-computation; the result must not move
      if (c == 4 && scramble) begin
        for (int i = 0; i < 8; i++) set_reg(i, 8'($urandom));
      end
    end
  endtask

  initial begin
    load_default();
    conf_exp      = 1'b0;
    pipe_write    = 1'b1;
    pipe_destreg  = 3'd5;
    pipe_wrt_data = 8'hAA;
    #2;
    check("init_busy", busy, 0);
    check("init_stall", stall, 0);
    check("init_done", done, 0);
    check("init_conflict", conflict, 0);
    check("init_rf_write", rf_write, 1);
    check("init_rf_dest", rf_destreg, 5);
    check("init_rf_data", rf_wrt_data, 8'hAA);
    pipe_write = 1'b0;
    #5;
    reset = 1'b0;

    // Default registers: expect 6, 7, 26, 31
    do_op(0, 3'd0, 8'd0, -1, -1, -1, 0, 0);
    check("dflt_c00", rf[0], 6);
    check("dflt_c01", rf[1], 7);
    check("dflt_c10", rf[2], 26);
    check("dflt_c11", rf[3], 31);
    cmp_rf();

    // Truncation
    load_fill(8'h10, 8'h10);
    do_op(0, 3'd0, 8'd0, -1, -1, -1, 0, 0);
    cmp_rf();
    load_fill(8'h0F, 8'h11);
    do_op(0, 3'd0, 8'd0, -1, -1, -1, 0, 0);
    check("ovf_c00", rf[0], 8'hFE);
    cmp_rf();

    // Dropped pipeline write in cycle 5
    load_default();
    do_op(0, 3'd0, 8'd0, 5, -1, -1, 0, 0);
    cmp_rf();

    // Same-cycle start and reg1 = 9
    load_default();
    do_op(1, 3'd1, 8'd9, -1, -1, -1, 0, 0);
    check("fwd_c00", rf[0], 54);
    cmp_rf();

    // Reset after the reg0 write, then a clean run
    load_default();
    do_op(0, 3'd0, 8'd0, -1, -1, 11, 0, 0);
    check("abort_reg0", rf[0], 6);
    check("abort_reg1", rf[1], 1);
    cmp_rf();
    do_op(0, 3'd0, 8'd0, -1, -1, -1, 0, 0);
    cmp_rf();

    // Restart during MAC is ignored; held start repeats every 15 cycles
    load_default();
    do_op(0, 3'd0, 8'd0, -1, 5, -1, 0, 0);
    do_op(0, 3'd0, 8'd0, -1, -1, -1, 1, 0);
    do_op(0, 3'd0, 8'd0, -1, -1, -1, 1, 1);
    do_op(0, 3'd0, 8'd0, -1, -1, -1, 1, 0);
    cmp_rf();

    // Randomized operations
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) set_reg(i, 8'($urandom));
      do_op(1'($urandom), 3'($urandom), 8'($urandom),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : -1,
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : -1,
            -1, 1'($urandom), 1'($urandom));
      cmp_rf();
    end

    @(negedge clk);
    start      = 1'b0;
    pipe_write = 1'b0;
    #1;
    check("final_busy", busy, 0);
    check("final_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The block SHALL have input clk, 1 bit, the system clock; all state updates on the rising edge.
REQ-002 The block SHALL have input reset, 1 bit, asynchronous and active-high.
REQ-003 The block SHALL have input start, 1 bit, a request to compute C = A x B (2x2, 8-bit).
REQ-004 The block SHALL have inputs A0..A3, each 8 bits, carrying register file regs 0..3 as A row-major (a00, a01, a10, a11).
REQ-005 The block SHALL have inputs B0..B3, each 8 bits, carrying register file regs 4..7 as B row-major (b00, b01, b10, b11).
REQ-006 The block SHALL have inputs pipe_write (1 bit), pipe_destreg (3 bits) and pipe_wrtData (8 bits), the pipeline writeback request.
REQ-007 The block SHALL have outputs rf_write (1 bit), rf_destreg (3 bits) and rf_wrtData (8 bits), driving the register file write port.
REQ-008 The block SHALL have outputs busy, stall and done (1 bit each), plus conflict (1 bit), a sticky dropped-pipeline-write flag.

Function
REQ-009 The FSM SHALL have states IDLE, CAPTURE, MAC, WRITE and DONE.
REQ-010 In IDLE, start=1 SHALL move the FSM to CAPTURE at the next edge; otherwise it SHALL stay in IDLE.
REQ-011 CAPTURE SHALL last 1 cycle, latching A0..A3 and B0..B3 into internal snapshot registers, and then move to MAC.
REQ-012 MAC SHALL last 8 cycles: element index e=0..3 (C00, C01, C10, C11), and for each element k=0 then k=1.
REQ-013 In MAC, k=0 SHALL load acc = a[i][0]*b[0][j] and k=1 SHALL add acc + a[i][1]*b[1][j]; result[e] SHALL be stored after the k=1 step.
REQ-014 All products and sums SHALL be truncated to 8 bits (mod 256), with no saturation and no overflow flag.
REQ-015 WRITE SHALL last 4 cycles: cycle n drives rf_write=1, rf_destreg=n and rf_wrtData=result[n], for n=0..3.
REQ-016 DONE SHALL last 1 cycle with done=1, then the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be fixed: start sampled at edge 0 gives CAPTURE in cycle 1, MAC in cycles 2-9, WRITE in cycles 10-13 and DONE in cycle 14.
REQ-018 In IDLE, rf_write, rf_destreg and rf_wrtData SHALL equal pipe_write, pipe_destreg and pipe_wrtData combinationally.
REQ-019 In all non-IDLE states, the pipe_* inputs SHALL NOT reach the rf_* outputs.
REQ-020 In CAPTURE, MAC and DONE, rf_write SHALL be 0.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 stall SHALL equal busy, so that the pipeline holds writeback.
REQ-023 A pipe_write=1 while busy=1 SHALL be dropped and SHALL set conflict=1 at the next edge; conflict SHALL hold until reset.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 When start=1 and pipe_write=1 occur in the same IDLE cycle, the pipeline write SHALL be forwarded that cycle and CAPTURE SHALL sample the updated registers.
REQ-026 Snapshot registers SHALL isolate computation from the regs 0..3 writes, so results depend only on values captured in CAPTURE.
REQ-027 A start held high continuously SHALL produce back-to-back operations: IDLE for 1 cycle after DONE, then CAPTURE.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE; clear the snapshot, acc, results and counters to 0; set busy, stall, done and conflict to 0; and make rf_* follow pipe_*.
REQ-029 Reset asserted mid-operation SHALL abort with no further matmul writes; writes already performed SHALL remain in the register file.
REQ-030 After reset deasserts, the first start SHALL be accepted at the first rising edge.

Verification
REQ-031 Scenario, default register values: A=[0,1;2,3], B=[4,5;6,7], pulse start -> WRITE cycles write reg0..3 = 6, 7, 26, 31, and done=1 in cycle 14.
REQ-032 Scenario, overflow: all A=0x10, all B=0x10 -> results 0x00 x4; all A=0x0F, all B=0x11 -> results 0xFE x4.
REQ-033 Scenario, pipeline write in cycle 5 of an operation -> rf_write=0 in that cycle, conflict=1 from cycle 6, and results unchanged.
REQ-034 Scenario, same-cycle start and pipe_write(reg1=9) in IDLE -> reg1 is written, and the computation uses a01=9.
REQ-035 Scenario, reset asserted in cycle 11 (after the reg0 write) -> outputs are cleared immediately, reg1..3 are not written by the matmul, and a new start completes normally.
REQ-036 Scenario, start pulsed again during MAC -> ignored, exactly one DONE pulse, and start held high -> operations repeat every 15 cycles (14-cycle operation plus 1 IDLE cycle).
